// File: rtl/dmem_responder_s.sv
// ---------------------------------------------------------------------------
// dmem_responder_s
//
// Memory-side responder for the MEM-stage load/store interface. It takes one
// request at a time over a valid/ready handshake, performs a 32-bit word read
// or a byte-masked word write on an internal data array, and returns the
// response (data/error) a fixed LATENCY cycles after the request handshake.
// This models a slow data memory and gives the pipeline something real to
// stall against.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words (power of two, at least 2)
//   LATENCY      request-handshake cycle to first resp_valid cycle, 1..15
//
// Ports
//   clk         single clock, everything on the rising edge
//   rst         synchronous active-high reset (array contents are kept)
//   req_valid   request present
//   req_ready   responder can accept a request this cycle
//   req_write   1 = store, 0 = load
//   req_addr    byte address
//   req_wdata   store data
//   req_wstrb   store byte enables, bit i covers req_wdata[8i+7:8i]
//   resp_valid  response present
//   resp_ready  initiator accepts the response
//   resp_rdata  load data; 0 for stores and errored requests
//   resp_err    request was misaligned or out of range
// ---------------------------------------------------------------------------
module dmem_responder_s #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // A request is in error when it is not word aligned or when any address
  // bit above the word index is set.
  function automatic logic addr_err_f(input logic [31:0] addr);
    logic [31:0] high_bits;
    high_bits  = addr >> (AW + 2);
    addr_err_f = (addr[1:0] != 2'b00) || (high_bits != 32'd0);
  endfunction

  // FSM and output registers
  state_t      state_r;
  state_t      state_nxt_s;
  logic [3:0]  cnt_r;
  logic [3:0]  cnt_nxt_s;
  logic        req_ready_r;
  logic        req_ready_nxt_s;
  logic        resp_valid_r;
  logic        resp_valid_nxt_s;
  logic [31:0] resp_rdata_r;
  logic [31:0] resp_rdata_nxt_s;
  logic        resp_err_r;
  logic        resp_err_nxt_s;

  // Latched request fields
  logic        lat_write_r;
  logic [31:0] lat_addr_r;
  logic [31:0] lat_wdata_r;
  logic [3:0]  lat_wstrb_r;

  // Request currently being served: live inputs in IDLE (needed when
  // LATENCY==1 commits on the handshake edge), latched copy otherwise.
  logic          eff_write_s;
  logic [31:0]   eff_addr_s;
  logic [31:0]   eff_wdata_s;
  logic [3:0]    eff_wstrb_s;
  logic          eff_err_s;
  logic [AW-1:0] eff_idx_s;

  logic accept_s;
  logic enter_resp_s;
  logic commit_s;

  // Data array; intentionally not cleared by reset.
  logic [31:0] mem_r [DEPTH_WORDS];

  assign accept_s = (state_r == ST_IDLE) && req_valid && req_ready_r;

  // Select the request fields that the commit/read path works on.
  always_comb begin
    if (state_r == ST_IDLE) begin
      eff_write_s = req_write;
      eff_addr_s  = req_addr;
      eff_wdata_s = req_wdata;
      eff_wstrb_s = req_wstrb;
    end else begin
      eff_write_s = lat_write_r;
      eff_addr_s  = lat_addr_r;
      eff_wdata_s = lat_wdata_r;
      eff_wstrb_s = lat_wstrb_r;
    end
  end

  assign eff_err_s = addr_err_f(eff_addr_s);
  assign eff_idx_s = eff_addr_s[AW+1:2];

  // Next-state, counter and registered-output next values.
  always_comb begin
    state_nxt_s      = state_r;
    cnt_nxt_s        = cnt_r;
    req_ready_nxt_s  = req_ready_r;
    resp_valid_nxt_s = resp_valid_r;
    resp_rdata_nxt_s = resp_rdata_r;
    resp_err_nxt_s   = resp_err_r;
    enter_resp_s     = 1'b0;
    commit_s         = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (LATENCY == 1) begin
            state_nxt_s = ST_RESP;
            cnt_nxt_s   = 4'd0;
          end else begin
            state_nxt_s = ST_WAIT;
            cnt_nxt_s   = CNT_LOAD;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 4'd1) begin
          state_nxt_s = ST_RESP;
          cnt_nxt_s   = 4'd0;
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 4'd0;
      end
    endcase

    // The edge that enters RESP is both the store commit edge and the load
    // sampling edge, so a load always sees every earlier committed store.
    enter_resp_s     = (state_nxt_s == ST_RESP) && (state_r != ST_RESP);
    commit_s         = enter_resp_s && eff_write_s && !eff_err_s;
    req_ready_nxt_s  = (state_nxt_s == ST_IDLE);
    resp_valid_nxt_s = (state_nxt_s == ST_RESP);

    if (enter_resp_s) begin
      if (!eff_write_s && !eff_err_s) begin
        resp_rdata_nxt_s = mem_r[eff_idx_s];
      end else begin
        resp_rdata_nxt_s = 32'd0;
      end
      resp_err_nxt_s = eff_err_s;
    end else if (state_nxt_s == ST_RESP) begin
      resp_rdata_nxt_s = resp_rdata_r;
      resp_err_nxt_s   = resp_err_r;
    end else begin
      resp_rdata_nxt_s = 32'd0;
      resp_err_nxt_s   = 1'b0;
    end
  end

  // State, counter, output and request-latch registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 4'd0;
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 32'd0;
      resp_err_r   <= 1'b0;
      lat_write_r  <= 1'b0;
      lat_addr_r   <= 32'd0;
      lat_wdata_r  <= 32'd0;
      lat_wstrb_r  <= 4'd0;
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      req_ready_r  <= req_ready_nxt_s;
      resp_valid_r <= resp_valid_nxt_s;
      resp_rdata_r <= resp_rdata_nxt_s;
      resp_err_r   <= resp_err_nxt_s;
      if (accept_s) begin
        lat_write_r <= req_write;
        lat_addr_r  <= req_addr;
        lat_wdata_r <= req_wdata;
        lat_wstrb_r <= req_wstrb;
      end
    end
  end

  // Byte-masked store into the array; a reset on the commit edge drops it.
  always_ff @(posedge clk) begin
    if (!rst && commit_s) begin
      for (int b = 0; b < 4; b++) begin
        if (eff_wstrb_s[b]) begin
          mem_r[eff_idx_s][8*b +: 8] <= eff_wdata_s[8*b +: 8];
        end
      end
    end
  end

  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_rdata = resp_rdata_r;
  assign resp_err   = resp_err_r;

endmodule
